// File: rtl/approx_mult_error_monitor_pkg.sv
// approx_mult_pkg: shared widths, FSM state and ED result
// bundle for the approximate-multiplier error monitor.
package approx_mult_pkg;

  localparam int W     = 8;
  localparam int PW    = 2 * W;
  localparam int CNT_W = 17;
  localparam int ACC_W = PW + CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [PW-1:0] prod;
    logic [PW-1:0] ed;
    logic          nz;
  } ed_res_t;

endpackage

// File: rtl/approx_mult_error_monitor_if.sv
// approx_mult_error_monitor_if: operand/product triple
// handshake from the multiplier under test.
interface approx_mult_error_monitor_if;
  import approx_mult_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [PW-1:0] z_approx;

  modport master (
    output in_valid,
    output x,
    output y,
    output z_approx,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  x,
    input  y,
    input  z_approx,
    output in_ready
  );

endinterface

// File: rtl/approx_mult_error_monitor_ed_calc_stage.sv
// ed_calc_stage: registered stage computing exact product
// and |x*y - z_approx| with valid and operand pass-through.
module ed_calc_stage
  import approx_mult_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [W-1:0]  i_x,
  input  logic [W-1:0]  i_y,
  input  logic [PW-1:0] i_z,
  output logic          o_valid,
  output logic [W-1:0]  o_x,
  output logic [W-1:0]  o_y,
  output ed_res_t       o_res
);

  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_ed;

  logic          r_valid;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  ed_res_t       r_res;

  assign w_prod = PW'(i_x) * PW'(i_y);
  assign w_ed   = (i_z > w_prod) ? (i_z - w_prod)
                                 : (w_prod - i_z);

  // capture product and ED for the stats stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_res   <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_x       <= i_x;
        r_y       <= i_y;
        r_res.prod <= w_prod;
        r_res.ed   <= w_ed;
        r_res.nz   <= (w_ed != '0);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_res   = r_res;

endmodule

// File: rtl/approx_mult_error_monitor.sv
// approx_mult_error_monitor: accumulates error-distance
// statistics of an approximate multiplier over N samples.
module approx_mult_error_monitor
  import approx_mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  approx_mult_error_monitor_if.slave s_if,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_ed,
  output logic [PW-1:0]    max_ed,
  output logic [W-1:0]     max_x,
  output logic [W-1:0]     max_y,
  output logic [CNT_W-1:0] err_cnt
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_cnt;

  logic             r_s1_valid;
  logic [W-1:0]     r_s1_x;
  logic [W-1:0]     r_s1_y;
  logic [PW-1:0]    r_s1_z;

  logic             w_s2_valid;
  logic [W-1:0]     w_s2_x;
  logic [W-1:0]     w_s2_y;
  ed_res_t          w_s2_res;

  logic [ACC_W-1:0] r_sum;
  logic [PW-1:0]    r_max;
  logic [W-1:0]     r_max_x;
  logic [W-1:0]     r_max_y;
  logic [CNT_W-1:0] r_err;

  logic             w_xfer;
  logic             w_last;
  logic             w_start_ok;
  logic             w_unused;

  assign s_if.in_ready = (r_state == RUN);
  assign w_xfer     = (r_state == RUN) && s_if.in_valid;
  assign w_last     = w_xfer && ((r_cnt + CNT_W'(1)) == r_target);
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_unused   = ^w_s2_res.prod;

  // next-state selection
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (start)
          w_state_nxt = (num_samples == '0) ? DONE : RUN;
      end
      RUN: begin
        if (w_last)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_s1_valid && !w_s2_valid)
          w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, target latch and accepted-sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_target <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_target <= num_samples;
        r_cnt    <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // input register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_z     <= '0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_x <= s_if.x;
        r_s1_y <= s_if.y;
        r_s1_z <= s_if.z_approx;
      end
    end
  end

  ed_calc_stage u_ed (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_s1_valid),
    .i_x     (r_s1_x),
    .i_y     (r_s1_y),
    .i_z     (r_s1_z),
    .o_valid (w_s2_valid),
    .o_x     (w_s2_x),
    .o_y     (w_s2_y),
    .o_res   (w_s2_res)
  );

  // statistics: cleared on start, updated per ED result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_max   <= '0;
      r_max_x <= '0;
      r_max_y <= '0;
      r_err   <= '0;
    end else if (w_start_ok) begin
      r_sum   <= '0;
      r_max   <= '0;
      r_max_x <= '0;
      r_max_y <= '0;
      r_err   <= '0;
    end else if (w_s2_valid) begin
      r_sum <= r_sum + ACC_W'(w_s2_res.ed);
      r_err <= r_err + CNT_W'(w_s2_res.nz);
      if (w_s2_res.ed > r_max) begin
        r_max   <= w_s2_res.ed;
        r_max_x <= w_s2_x;
        r_max_y <= w_s2_y;
      end
    end
  end

  assign busy    = (r_state == RUN) || (r_state == DRAIN);
  assign done    = (r_state == DONE);
  assign sum_ed  = r_sum;
  assign max_ed  = r_max;
  assign max_x   = r_max_x;
  assign max_y   = r_max_y;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// tb_approx_mult_error_monitor: directed vectors with a
// scoreboard of expected per-run statistics.
module tb_approx_mult_error_monitor;
  import approx_mult_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] sum_ed;
  logic [PW-1:0]    max_ed;
  logic [W-1:0]     max_x;
  logic [W-1:0]     max_y;
  logic [CNT_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  approx_mult_error_monitor_if u_if ();

  approx_mult_error_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .s_if        (u_if),
    .busy        (busy),
    .done        (done),
    .sum_ed      (sum_ed),
    .max_ed      (max_ed),
    .max_x       (max_x),
    .max_y       (max_y),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [PW-1:0]    med;
    logic [W-1:0]     mx;
    logic [W-1:0]     my;
    logic [CNT_W-1:0] err;
  } exp_t;

  exp_t q[$];
  exp_t m;

  logic [W-1:0]  vx [10];
  logic [W-1:0]  vy [10];
  logic [PW-1:0] vz [10];
  int            dl [10] = '{0, 5, -3, 100, 0, -100, 7, 7, -1, 0};

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] ed_of(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [PW-1:0] z);
    int p;
    int zi;
    p  = int'(a) * int'(b);
    zi = int'(z);
    return (p > zi) ? PW'(p - zi) : PW'(zi - p);
  endfunction

  task automatic m_clear();
    m.sum = '0;
    m.med = '0;
    m.mx  = '0;
    m.my  = '0;
    m.err = '0;
  endtask

  task automatic m_add(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [PW-1:0] z);
    logic [PW-1:0] e;
    e = ed_of(a, b, z);
    m.sum = m.sum + ACC_W'(e);
    if (e != 0) m.err = m.err + 1'b1;
    if (e > m.med) begin
      m.med = e;
      m.mx  = a;
      m.my  = b;
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    @(negedge clk);
    start       = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic [PW-1:0] z);
    @(negedge clk);
    start          = 1'b0;
    u_if.in_valid  = 1'b1;
    u_if.x         = a;
    u_if.y         = b;
    u_if.z_approx  = z;
  endtask

  task automatic stop_in();
    @(negedge clk);
    u_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && !done; c++) @(negedge clk);
    chk("done_seen", done, 1);
  endtask

  // scoreboard monitor: compare stats when done rises
  initial begin
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !pd) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("run_sum_ed", sum_ed, e.sum);
          chk("run_max_ed", max_ed, e.med);
          chk("run_max_x", max_x, e.mx);
          chk("run_max_y", max_y, e.my);
          chk("run_err_cnt", err_cnt, e.err);
        end
      end
      pd = done;
    end
  end

  initial begin
    u_if.in_valid = 1'b0;
    u_if.x        = '0;
    u_if.y        = '0;
    u_if.z_approx = '0;
    for (int i = 0; i < 10; i++) begin
      vx[i] = W'(i * 23 + 5);
      vy[i] = W'(250 - i * 19);
      vz[i] = PW'(int'(vx[i]) * int'(vy[i]) + dl[i]);
    end

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", u_if.in_ready, 0);
    chk("rst_sum", sum_ed, 0);
    chk("rst_err", err_cnt, 0);
    rst_n = 1'b1;

    // num_samples = 0 goes straight to DONE
    m_clear();
    q.push_back(m);
    @(negedge clk);
    start       = 1'b1;
    num_samples = '0;
    chk("zero_ready_idle", u_if.in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_ready", u_if.in_ready, 0);
    repeat (2) @(negedge clk);
    chk("zero_ready_late", u_if.in_ready, 0);

    // single worst-case sample with done latency
    q.push_back('{sum: 65025, med: 65025, mx: 255, my: 255, err: 1});
    do_start(1);
    chk("single_done_drop", done, 0);
    send(8'd255, 8'd255, 16'd0);
    @(posedge clk);
    #1 u_if.in_valid = 1'b0;
    chk("single_busy_k", busy, 1);
    chk("single_done_k", done, 0);
    @(posedge clk);
    #1 chk("single_done_k1", done, 0);
    @(posedge clk);
    #1 chk("single_done_k2", done, 0);
    chk("single_sum_k2", sum_ed, 65025);
    @(posedge clk);
    #1 chk("single_done_k3", done, 1);

    // overshoot and tie
    q.push_back('{sum: 12, med: 8, mx: 3, my: 4, err: 3});
    do_start(3);
    send(8'd3, 8'd4, 16'd20);
    send(8'd2, 8'd1, 16'd0);
    send(8'd5, 8'd5, 16'd27);
    stop_in();
    wait_done(20);

    // gaps plus ignored start during RUN
    m_clear();
    for (int i = 0; i < 10; i++) m_add(vx[i], vy[i], vz[i]);
    q.push_back(m);
    do_start(10);
    for (int i = 0; i < 10; i++) begin
      send(vx[i], vy[i], vz[i]);
      @(negedge clk);
      u_if.in_valid = 1'b0;
      if (i == 3) begin
        start       = 1'b1;
        num_samples = 17'd3;
        chk("gap_busy", busy, 1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(20);

    // reset mid-run, then full rerun
    do_start(10);
    for (int i = 0; i < 5; i++) send(vx[i], vy[i], vz[i]);
    stop_in();
    repeat (3) @(negedge clk);
    chk("pre_abort_err", err_cnt, 3);
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", u_if.in_ready, 0);
    chk("abort_sum", sum_ed, 0);
    chk("abort_max", max_ed, 0);
    chk("abort_mx", max_x, 0);
    chk("abort_my", max_y, 0);
    chk("abort_err", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(m);
    do_start(10);
    for (int i = 0; i < 10; i++) send(vx[i], vy[i], vz[i]);
    stop_in();
    wait_done(20);

    // exhaustive exact model
    m_clear();
    q.push_back(m);
    do_start(17'd65536);
    for (int i = 0; i < 65536; i++)
      send(W'(i >> 8), W'(i & 255), PW'((i >> 8) * (i & 255)));
    stop_in();
    wait_done(20);

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
